// File: rtl/sequence_controller_if.sv
// Control bundle between the sequence controller and the CPU datapath.
// master: the controller side; slave: the datapath side.
interface sequence_controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic       sel;
  logic       rd;
  logic       ld_ir;
  logic       inc_pc;
  logic       ld_pc;
  logic       ld_ac;
  logic       wr;
  logic       data_e;
  logic       halt;
  logic [2:0] phase;

  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
  );
endinterface

// File: rtl/sequence_controller.sv
// Eight-phase instruction sequencer for a simple accumulator CPU.
// The opcode is captured once per instruction (in IDLE) and all later
// phases decode only that captured copy. HLT parks the machine in HALTED.
module sequence_controller (
  input  logic                         clk,
  input  logic                         reset,
  sequence_controller_if.master        bus
);

  typedef enum logic [3:0] {
    StInstAddr  = 4'd0,
    StInstFetch = 4'd1,
    StInstLoad  = 4'd2,
    StIdle      = 4'd3,
    StOpAddr    = 4'd4,
    StOpFetch   = 4'd5,
    StAluOp     = 4'd6,
    StStore     = 4'd7,
    StHalted    = 4'd8
  } state_e;

  localparam logic [2:0] OpHlt = 3'b000;
  localparam logic [2:0] OpSkz = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpAnd = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpLda = 3'b101;
  localparam logic [2:0] OpSto = 3'b110;
  localparam logic [2:0] OpJmp = 3'b111;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       aluop;

  assign aluop = (op_q == OpAdd) || (op_q == OpAnd) || (op_q == OpXor) || (op_q == OpLda);

  // State and captured opcode; synchronous active-low reset has priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StInstAddr;
      op_q    <= OpHlt;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Next-state: one phase per clock, opcode latched only in IDLE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      StInstAddr:  state_d = StInstFetch;
      StInstFetch: state_d = StInstLoad;
      StInstLoad:  state_d = StIdle;
      StIdle: begin
        op_d    = bus.opcode;
        state_d = StOpAddr;
      end
      StOpAddr:    state_d = (op_q == OpHlt) ? StHalted : StOpFetch;
      StOpFetch:   state_d = StAluOp;
      StAluOp:     state_d = StStore;
      StStore:     state_d = StInstAddr;
      StHalted:    state_d = StHalted;
      default:     state_d = StInstAddr;
    endcase
  end

  // Output decode from state, captured opcode and zero flag.
  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.wr     = 1'b0;
    bus.data_e = 1'b0;
    bus.halt   = 1'b0;
    bus.phase  = state_q[2:0];
    unique case (state_q)
      StInstAddr:  bus.sel = 1'b1;
      StInstFetch: begin
        bus.sel = 1'b1;
        bus.rd  = 1'b1;
      end
      StInstLoad, StIdle: begin
        bus.sel   = 1'b1;
        bus.rd    = 1'b1;
        bus.ld_ir = 1'b1;
      end
      StOpAddr:    bus.inc_pc = 1'b1;
      StOpFetch:   bus.rd = aluop;
      StAluOp: begin
        bus.rd     = aluop;
        bus.inc_pc = (op_q == OpSkz) && bus.zero;
        bus.ld_pc  = (op_q == OpJmp);
        bus.data_e = (op_q == OpSto);
      end
      StStore: begin
        bus.rd     = aluop;
        bus.ld_ac  = aluop;
        bus.ld_pc  = (op_q == OpJmp);
        bus.wr     = (op_q == OpSto);
        bus.data_e = (op_q == OpSto);
      end
      StHalted: begin
        bus.halt  = 1'b1;
        bus.phase = 3'd4;
      end
      default:     bus.sel = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sequence_controller.sv
// Self-checking bench for sequence_controller: directed scenarios plus a
// randomized run, all compared against a behavioural phase/opcode model.
module tb_sequence_controller;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  sequence_controller_if bus ();

  sequence_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int         m_phase;
  logic [2:0] m_op;
  bit         m_halted;

  // Expected vector {halt,sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,phase[2:0]}
  function automatic logic [11:0] model_out(int ph, logic [2:0] op, logic z, bit halted);
    bit aluop;
    bit sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e;
    if (halted) return {1'b1, 8'b0, 3'd4};
    aluop  = (op >= 3'd2) && (op <= 3'd5);
    sel    = (ph <= 3);
    rd     = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
    ld_ir  = (ph == 2) || (ph == 3);
    inc_pc = (ph == 4) || (ph == 6 && op == 3'd1 && z);
    ld_pc  = (op == 3'd7) && (ph >= 6);
    ld_ac  = (ph == 7) && aluop;
    wr     = (ph == 7) && (op == 3'd6);
    data_e = (ph >= 6) && (op == 3'd6);
    return {1'b0, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, 3'(ph)};
  endfunction

  // Drive one cycle, sample outputs mid-cycle, then advance the model at the edge.
  task automatic step(input logic [2:0] op, input logic z, input logic rst,
                      output logic [11:0] obs, output logic [11:0] exp);
    @(negedge clk);
    bus.opcode = op;
    bus.zero   = z;
    reset      = rst;
    #1;
    obs = {bus.halt, bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc, bus.ld_ac,
           bus.wr, bus.data_e, bus.phase};
    exp = model_out(m_phase, m_op, z, m_halted);
    @(posedge clk);
    if (!rst) begin
      m_phase  = 0;
      m_op     = 3'd0;
      m_halted = 0;
    end else if (!m_halted) begin
      if (m_phase == 3) m_op = op;
      if (m_phase == 4 && m_op == 3'd0) m_halted = 1;
      else m_phase = (m_phase + 1) % 8;
    end
  endtask

  task automatic do_reset();
    logic [11:0] o, e;
    step(3'd0, 1'b0, 1'b0, o, e);
  endtask

  task automatic test_reset();
    logic [11:0] o, e;
    step(3'd5, 1'b1, 1'b0, o, e);
    for (int i = 0; i < 3; i++) begin
      step(3'($urandom_range(7)), 1'($urandom_range(1)), 1'b0, o, e);
      n_checks++;
      if (o !== 12'b0100_0000_0000) begin
        n_errors++;
        $display("FAIL reset_hold%0d: got %b expected %b", i, o, 12'b0100_0000_0000);
      end
    end
    // first released edge must move to phase 1
    step(3'd2, 1'b0, 1'b1, o, e);
    step(3'd2, 1'b0, 1'b1, o, e);
    n_checks++;
    if (o[2:0] !== 3'd1) begin
      n_errors++;
      $display("FAIL reset_release_phase: got %0d expected 1", o[2:0]);
    end
  endtask

  task automatic test_add();
    logic [11:0] o, e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(3'd2, 1'($urandom_range(1)), 1'b1, o, e);
      n_checks++;
      if (o !== e || o[2:0] !== 3'(i % 8) || o[9] !== (i % 8 inside {1, 2, 3, 5, 6, 7}) ||
          o[5] !== (i == 7) || o[7] !== (i % 8 == 4)) begin
        n_errors++;
        $display("FAIL add_cycle%0d: got %b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_skz();
    logic [11:0] o, e;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(3'd1, (i < 8), 1'b1, o, e);
      n_checks++;
      if (o !== e || o[7] !== (i == 4 || i == 6 || i == 12)) begin
        n_errors++;
        $display("FAIL skz_cycle%0d: got %b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_sto();
    logic [11:0] o, e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(3'd6, 1'b0, 1'b1, o, e);
      n_checks++;
      if (o !== e || o[3] !== (i >= 6) || o[4] !== (i == 7) || (i >= 5 && o[9] !== 1'b0)) begin
        n_errors++;
        $display("FAIL sto_cycle%0d: got %b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_jmp();
    logic [11:0] o, e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(3'd7, 1'b1, 1'b1, o, e);
      n_checks++;
      if (o !== e || o[6] !== (i >= 6) || (i >= 6 && o[7] !== 1'b0)) begin
        n_errors++;
        $display("FAIL jmp_cycle%0d: got %b expected %b", i, o, e);
      end
    end
  endtask

  task automatic test_halt();
    logic [11:0] o, e;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      step(3'($urandom_range(7)), 1'($urandom_range(1)), 1'b1, o, e);
      if (i == 3) begin
        // opcode is latched here; force HLT for this capture
      end
      n_checks++;
      if (o !== e || (i == 4 && o[7] !== 1'b1) ||
          (i >= 5 && o !== 12'b1000_0000_0100)) begin
        n_errors++;
        $display("FAIL halt_cycle%0d: got %b expected %b", i, o, e);
      end
      if (i == 2) begin
        // next step is the IDLE capture: drive HLT there
        step(3'd0, 1'b0, 1'b1, o, e);
        i++;
        n_checks++;
        if (o !== e) begin
          n_errors++;
          $display("FAIL halt_idle: got %b expected %b", o, e);
        end
      end
    end
    do_reset();
    step(3'd0, 1'b0, 1'b1, o, e);
    n_checks++;
    if (o !== 12'b0100_0000_0000) begin
      n_errors++;
      $display("FAIL halt_exit: got %b expected %b", o, 12'b0100_0000_0000);
    end
  endtask

  task automatic test_opcode_change();
    logic [11:0] o, e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step((i >= 5) ? 3'd6 : 3'd2, 1'b0, (i != 6), o, e);
      n_checks++;
      if (o !== e || (i == 5 && o[9] !== 1'b1) || (i == 6 && o[3] !== 1'b0)) begin
        n_errors++;
        $display("FAIL opchg_cycle%0d: got %b expected %b", i, o, e);
      end
      if (i == 6) begin
        step(3'd6, 1'b0, 1'b1, o, e);
        n_checks++;
        if (o[2:0] !== 3'd0 || o !== e) begin
          n_errors++;
          $display("FAIL opchg_midreset: got %b expected %b", o, e);
        end
        break;
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] o, e;
    logic        r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(39) != 0);
      step(3'($urandom_range(7)), 1'($urandom_range(1)), r, o, e);
      n_checks++;
      if (o !== e || (o[6] && o[7]) || (o[4] && !o[3])) begin
        n_errors++;
        $display("FAIL random_cycle%0d: got %b expected %b", i, o, e);
      end
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    m_phase     = 0;
    m_op        = 3'd0;
    m_halted    = 0;
    reset       = 1'b0;
    bus.opcode  = 3'd0;
    bus.zero    = 1'b0;
    test_reset();
    test_add();
    test_skz();
    test_sto();
    test_jmp();
    test_halt();
    test_opcode_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
